// File: rtl/mem_stage_pkg.sv
// Shared constants for the RV32I memory stage: funct3 codes, align-code layout, FSM states
// and load-extension helpers.
package mem_stage_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam int ALIGN_STORE_BIT = 3;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_BUSY = 1'b1
  } mem_state_e;

  function automatic logic [31:0] ext_byte(input logic [7:0] b, input logic sgn);
    return {{24{sgn & b[7]}}, b};
  endfunction

  function automatic logic [31:0] ext_half(input logic [15:0] h, input logic sgn);
    return {{16{sgn & h[15]}}, h};
  endfunction

endpackage

// File: rtl/mem_align_unit.sv
// Combinational store lane replication / byte enables, load lane extract / extension and,
// with MEM_MISALIGN_TRAP_EN, misalignment detection.
module mem_align_unit
  import mem_stage_pkg::*;
(
  input  logic        is_store,
  input  logic [2:0]  funct3,
  input  logic [1:0]  off_raw,
  input  logic [31:0] store_data,
  input  logic [31:0] load_word,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic        misalign,
`endif
  output logic [31:0] wdata,
  output logic [3:0]  be,
  output logic [31:0] load_data
);

  logic [1:0]  off;
  logic [31:0] shifted;
  logic [15:0] half;

  // Effective lane offset; without the trap, misaligned low bits are dropped.
  always_comb begin
    off = off_raw;
`ifdef MEM_MISALIGN_TRAP_EN
    misalign = 1'b0;
    case (funct3[1:0])
      2'b01:   misalign = off_raw[0];
      2'b10:   misalign = (off_raw != 2'b00);
      default: misalign = 1'b0;
    endcase
`else
    case (funct3[1:0])
      2'b01:   off = {off_raw[1], 1'b0};
      2'b10:   off = 2'b00;
      default: off = off_raw;
    endcase
`endif
  end

  // Store lane replication and byte enables; loads always enable the full word.
  always_comb begin
    wdata = store_data;
    be    = 4'b1111;
    if (is_store) begin
      case (funct3)
        F3_SB: begin
          wdata = {4{store_data[7:0]}};
          be    = 4'b0001 << off;
        end
        F3_SH: begin
          wdata = {2{store_data[15:0]}};
          be    = off[1] ? 4'b1100 : 4'b0011;
        end
        default: begin
          wdata = store_data;
          be    = 4'b1111;
        end
      endcase
    end else begin
      be = 4'b1111;
    end
  end

  // Load lane extract and sign/zero extension.
  always_comb begin
    shifted = load_word >> {off, 3'b000};
    half    = off[1] ? load_word[31:16] : load_word[15:0];
    case (funct3)
      F3_LB:   load_data = ext_byte(shifted[7:0], 1'b1);
      F3_LBU:  load_data = ext_byte(shifted[7:0], 1'b0);
      F3_LH:   load_data = ext_half(half, 1'b1);
      F3_LHU:  load_data = ext_half(half, 1'b0);
      F3_LW:   load_data = load_word;
      default: load_data = load_word;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// RV32I memory stage: IDLE/BUSY FSM driving a req/ack data-memory port, registered WB bundle.
// Optional MEM_MISALIGN_TRAP_EN turns misaligned half/word accesses into a trap pulse.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              valid_i,
  input  logic [DATA_W-1:0] result_i,
  input  logic [DATA_W-1:0] write_data_i,
  input  logic [3:0]        align_i,
  input  logic [4:0]        rd_addr_i,
  input  logic              memread_i,
  input  logic              memwrite_i,
  input  logic              memtoreg_i,
  input  logic              regwrite_i,
  output logic              stall_o,
  output logic              dmem_req,
  output logic              dmem_we,
  output logic [ADDR_W-1:0] dmem_addr,
  output logic [DATA_W-1:0] dmem_wdata,
  output logic [3:0]        dmem_be,
  input  logic [DATA_W-1:0] dmem_rdata,
  input  logic              dmem_ack,
`ifdef MEM_MISALIGN_TRAP_EN
  output logic              misalign_o,
  output logic [31:0]       misalign_addr_o,
`endif
  output logic              wb_valid,
  output logic [4:0]        wb_rd_addr,
  output logic              wb_regwrite,
  output logic [DATA_W-1:0] wb_data
);

  mem_state_e        state_q, state_d;
  logic              req_q, req_d, we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d, res_q, res_d;
  logic [3:0]        be_q, be_d;
  logic [2:0]        f3_q, f3_d;
  logic [1:0]        off_q, off_d;
  logic [4:0]        rd_q, rd_d;
  logic              rw_q, rw_d, m2r_q, m2r_d;
  logic              wb_valid_q, wb_valid_d, wb_rw_q, wb_rw_d;
  logic [4:0]        wb_rd_q, wb_rd_d;
  logic [DATA_W-1:0] wb_data_q, wb_data_d;
  logic              trap;
  logic [2:0]        au_f3;
  logic [1:0]        au_off;
  logic [31:0]       au_wdata, au_load;
  logic [3:0]        au_be;

  // In BUSY the unit decodes the captured access so upstream input changes cannot disturb the load.
  assign au_f3  = (state_q == MEM_BUSY) ? f3_q  : align_i[2:0];
  assign au_off = (state_q == MEM_BUSY) ? off_q : result_i[1:0];

`ifdef MEM_MISALIGN_TRAP_EN
  logic        mis_q, mis_d, au_mis;
  logic [31:0] mis_addr_q, mis_addr_d;
  assign trap            = au_mis;
  assign misalign_o      = mis_q;
  assign misalign_addr_o = mis_addr_q;
`else
  assign trap = 1'b0;
`endif

  mem_align_unit u_align (
    .is_store   (align_i[ALIGN_STORE_BIT]),
    .funct3     (au_f3),
    .off_raw    (au_off),
    .store_data (write_data_i),
    .load_word  (dmem_rdata),
`ifdef MEM_MISALIGN_TRAP_EN
    .misalign   (au_mis),
`endif
    .wdata      (au_wdata),
    .be         (au_be),
    .load_data  (au_load)
  );

  // Next-state, dmem capture and WB bundle formation.
  always_comb begin
    state_d    = state_q;
    req_d      = req_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    be_d       = be_q;
    f3_d       = f3_q;
    off_d      = off_q;
    res_d      = res_q;
    rd_d       = rd_q;
    rw_d       = rw_q;
    m2r_d      = m2r_q;
    wb_valid_d = 1'b0;
    wb_rd_d    = wb_rd_q;
    wb_rw_d    = wb_rw_q;
    wb_data_d  = wb_data_q;
`ifdef MEM_MISALIGN_TRAP_EN
    mis_d      = 1'b0;
    mis_addr_d = mis_addr_q;
`endif
    case (state_q)
      MEM_IDLE: begin
        if (valid_i && (memread_i || memwrite_i) && trap) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_addr_i;
          wb_rw_d    = 1'b0;
          wb_data_d  = result_i;
`ifdef MEM_MISALIGN_TRAP_EN
          mis_d      = 1'b1;
          mis_addr_d = result_i;
`endif
        end else if (valid_i && (memread_i || memwrite_i)) begin
          state_d = MEM_BUSY;
          req_d   = 1'b1;
          we_d    = memwrite_i;
          addr_d  = {result_i[ADDR_W-1:2], 2'b00};
          wdata_d = au_wdata;
          be_d    = memwrite_i ? au_be : 4'b1111;
          f3_d    = align_i[2:0];
          off_d   = result_i[1:0];
          res_d   = result_i;
          rd_d    = rd_addr_i;
          rw_d    = regwrite_i && !memwrite_i && (rd_addr_i != 5'd0);
          m2r_d   = memtoreg_i;
        end else if (valid_i) begin
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_addr_i;
          wb_rw_d    = regwrite_i && (rd_addr_i != 5'd0);
          wb_data_d  = result_i;
        end else begin
          state_d = MEM_IDLE;
        end
      end
      MEM_BUSY: begin
        if (dmem_ack) begin
          state_d    = MEM_IDLE;
          req_d      = 1'b0;
          wb_valid_d = 1'b1;
          wb_rd_d    = rd_q;
          wb_rw_d    = rw_q;
          wb_data_d  = m2r_q ? au_load : res_q;
        end else begin
          state_d = MEM_BUSY;
        end
      end
      default: state_d = MEM_IDLE;
    endcase
  end

  // State and output registers; reset abandons any outstanding request.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= MEM_IDLE;
      req_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      be_q       <= 4'b0000;
      f3_q       <= 3'b000;
      off_q      <= 2'b00;
      res_q      <= '0;
      rd_q       <= 5'd0;
      rw_q       <= 1'b0;
      m2r_q      <= 1'b0;
      wb_valid_q <= 1'b0;
      wb_rd_q    <= 5'd0;
      wb_rw_q    <= 1'b0;
      wb_data_q  <= '0;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q      <= 1'b0;
      mis_addr_q <= 32'h0;
`endif
    end else begin
      state_q    <= state_d;
      req_q      <= req_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      be_q       <= be_d;
      f3_q       <= f3_d;
      off_q      <= off_d;
      res_q      <= res_d;
      rd_q       <= rd_d;
      rw_q       <= rw_d;
      m2r_q      <= m2r_d;
      wb_valid_q <= wb_valid_d;
      wb_rd_q    <= wb_rd_d;
      wb_rw_q    <= wb_rw_d;
      wb_data_q  <= wb_data_d;
`ifdef MEM_MISALIGN_TRAP_EN
      mis_q      <= mis_d;
      mis_addr_q <= mis_addr_d;
`endif
    end
  end

  assign stall_o     = (state_q == MEM_BUSY);
  assign dmem_req    = req_q;
  assign dmem_we     = we_q;
  assign dmem_addr   = addr_q;
  assign dmem_wdata  = wdata_q;
  assign dmem_be     = be_q;
  assign wb_valid    = wb_valid_q;
  assign wb_rd_addr  = wb_rd_q;
  assign wb_regwrite = wb_rw_q;
  assign wb_data     = wb_data_q;

endmodule
